// File: rtl/video_timing_gen_if.sv
// Video timing interface: control inputs (clock enable, resync) and the
// decoded raster outputs of the timing generator.
interface video_timing_gen_if #(
    parameter int CW = 10,
    parameter int FW = 8
);
    logic          ce;
    logic          resync;
    logic          hsync;
    logic          vsync;
    logic          active;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          sof;
    logic          eol;
    logic [FW-1:0] frame;

    // Generator side: takes ce/resync, drives the raster outputs.
    modport master (
        input  ce,
        input  resync,
        output hsync,
        output vsync,
        output active,
        output x,
        output y,
        output sof,
        output eol,
        output frame
    );

    // Consumer side: drives ce/resync, observes the raster outputs.
    modport slave (
        output ce,
        output resync,
        input  hsync,
        input  vsync,
        input  active,
        input  x,
        input  y,
        input  sof,
        input  eol,
        input  frame
    );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator: horizontal/vertical counters with registered
// sync, active-region, coordinate, strobe and frame-count outputs.
// Every output is the decode of the counter value present before the
// clock-enabled edge, so outputs trail the counters by one ce cycle.
module video_timing_gen #(
    parameter int H_TOTAL     = 882,
    parameter int H_SYNC      = 135,
    parameter int H_ACT_START = 143,
    parameter int H_ACT_END   = 864,
    parameter int V_TOTAL     = 370,
    parameter int V_SYNC      = 16,
    parameter int V_ACT_START = 19,
    parameter int V_ACT_END   = 370,
    parameter bit HSYNC_POL   = 1'b1,
    parameter bit VSYNC_POL   = 1'b0,
    parameter int CW          = 10,
    parameter int FW          = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    video_timing_gen_if.master vid
);

    // Refuse to elaborate with an inconsistent raster description.
    generate
        if (!(CW >= 1 && CW < 31 && FW >= 1 &&
              H_SYNC <= H_ACT_START && H_ACT_START < H_ACT_END &&
              H_ACT_END <= H_TOTAL &&
              V_SYNC <= V_ACT_START && V_ACT_START < V_ACT_END &&
              V_ACT_END <= V_TOTAL &&
              H_TOTAL <= (1 << CW) && V_TOTAL <= (1 << CW))) begin : g_bad_params
            $error("video_timing_gen: inconsistent timing parameters");
        end
    endgenerate

    // Comparison thresholds are one bit wider than the counters so that a
    // bound equal to 2^CW is still representable.
    localparam logic [CW:0]   H_SYNC_C  = (CW+1)'(H_SYNC);
    localparam logic [CW:0]   H_AS_C    = (CW+1)'(H_ACT_START);
    localparam logic [CW:0]   H_AE_C    = (CW+1)'(H_ACT_END);
    localparam logic [CW:0]   V_SYNC_C  = (CW+1)'(V_SYNC);
    localparam logic [CW:0]   V_AS_C    = (CW+1)'(V_ACT_START);
    localparam logic [CW:0]   V_AE_C    = (CW+1)'(V_ACT_END);
    localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_OFFSET  = CW'(H_ACT_START);
    localparam logic [CW-1:0] V_OFFSET  = CW'(V_ACT_START);

    logic [CW-1:0] hc;
    logic [CW-1:0] vc;
    logic [FW-1:0] frame_q;

    logic          hsync_q;
    logic          vsync_q;
    logic          active_q;
    logic [CW-1:0] x_q;
    logic [CW-1:0] y_q;
    logic          sof_q;
    logic          eol_q;

    logic          hc_last;
    logic          vc_last;
    logic          h_act;
    logic          v_act;
    logic          act_dec;
    logic [CW-1:0] x_dec;
    logic [CW-1:0] y_dec;

    // Decode of the current counter position, registered below.
    always_comb begin
        hc_last = (hc == H_LAST);
        vc_last = (vc == V_LAST);
        h_act   = ({1'b0, hc} >= H_AS_C) && ({1'b0, hc} < H_AE_C);
        v_act   = ({1'b0, vc} >= V_AS_C) && ({1'b0, vc} < V_AE_C);
        act_dec = h_act && v_act;
        x_dec   = '0;
        y_dec   = '0;
        if (act_dec) begin
            x_dec = hc - H_OFFSET;
            y_dec = vc - V_OFFSET;
        end
    end

    // Raster position counters; resync restarts the frame even without ce.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc <= '0;
            vc <= '0;
        end else if (vid.resync) begin
            hc <= '0;
            vc <= '0;
        end else if (vid.ce) begin
            if (hc_last) begin
                hc <= '0;
                vc <= vc_last ? '0 : vc + CW'(1);
            end else begin
                hc <= hc + CW'(1);
            end
        end
    end

    // Frame counter steps on the last pixel of the frame, resync or not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q <= '0;
        end else if (vid.ce && hc_last && vc_last) begin
            frame_q <= frame_q + FW'(1);
        end
    end

    // Registered outputs; they hold (strobes included) while ce is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q  <= ~HSYNC_POL;
            vsync_q  <= ~VSYNC_POL;
            active_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            sof_q    <= 1'b0;
            eol_q    <= 1'b0;
        end else if (vid.ce) begin
            hsync_q  <= ({1'b0, hc} < H_SYNC_C) ? HSYNC_POL : ~HSYNC_POL;
            vsync_q  <= ({1'b0, vc} < V_SYNC_C) ? VSYNC_POL : ~VSYNC_POL;
            active_q <= act_dec;
            x_q      <= x_dec;
            y_q      <= y_dec;
            sof_q    <= (hc == '0) && (vc == '0);
            eol_q    <= hc_last;
        end
    end

    assign vid.hsync  = hsync_q;
    assign vid.vsync  = vsync_q;
    assign vid.active = active_q;
    assign vid.x      = x_q;
    assign vid.y      = y_q;
    assign vid.sof    = sof_q;
    assign vid.eol    = eol_q;
    assign vid.frame  = frame_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Testbench for video_timing_gen: a small-raster instance checked against a
// scoreboard model plus vector table and corner-case sequences, and a
// default-parameter instance checked over its first twenty lines.
module tb_video_timing_gen;

    localparam int SCW = 4;
    localparam int SFW = 2;

    logic clk = 1'b0;
    logic rst_sm;
    logic rst_df;

    int checks = 0;
    int passes = 0;

    // Free-running clock shared by both instances.
    always #5 clk = ~clk;

    video_timing_gen_if #(.CW(SCW), .FW(SFW)) vsm ();
    video_timing_gen_if vdf ();

    video_timing_gen #(
        .H_TOTAL(10), .H_SYNC(2), .H_ACT_START(3), .H_ACT_END(8),
        .V_TOTAL(4), .V_SYNC(1), .V_ACT_START(1), .V_ACT_END(4),
        .CW(SCW), .FW(SFW)
    ) dut_sm (
        .clk(clk),
        .rst_n(rst_sm),
        .vid(vsm)
    );

    video_timing_gen dut_df (
        .clk(clk),
        .rst_n(rst_df),
        .vid(vdf)
    );

    typedef struct packed {
        logic           hsync;
        logic           vsync;
        logic           active;
        logic [SCW-1:0] x;
        logic [SCW-1:0] y;
        logic           sof;
        logic           eol;
        logic [SFW-1:0] frame;
    } obs_t;

    typedef struct {
        logic ce;
        logic resync;
        obs_t exp;
    } vec_t;

    localparam obs_t SM_RESET = '{hsync: 1'b0, vsync: 1'b1, active: 1'b0,
                                  x: 4'd0, y: 4'd0, sof: 1'b0, eol: 1'b0,
                                  frame: 2'd0};

    vec_t vecs [24];
    obs_t expq [$];

    int   mhc;
    int   mvc;
    logic [SFW-1:0] mframe;
    obs_t mcur;

    // Gather the small instance's outputs into one comparable word.
    function automatic obs_t sample_sm();
        obs_t o;
        o.hsync  = vsm.hsync;
        o.vsync  = vsm.vsync;
        o.active = vsm.active;
        o.x      = vsm.x;
        o.y      = vsm.y;
        o.sof    = vsm.sof;
        o.eol    = vsm.eol;
        o.frame  = vsm.frame;
        return o;
    endfunction

    // Build an expected output record with frame count zero.
    function automatic obs_t mko(input logic hs, input logic vs, input logic act,
                                 input logic [SCW-1:0] xx, input logic [SCW-1:0] yy,
                                 input logic sf, input logic el);
        obs_t o;
        o.hsync  = hs;
        o.vsync  = vs;
        o.active = act;
        o.x      = xx;
        o.y      = yy;
        o.sof    = sf;
        o.eol    = el;
        o.frame  = '0;
        return o;
    endfunction

    function automatic vec_t mkv(input logic c, input logic r, input obs_t e);
        vec_t v;
        v.ce     = c;
        v.resync = r;
        v.exp    = e;
        return v;
    endfunction

    // Compare one value against its expectation and keep the tallies.
    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            passes++;
        end
    endtask

    // Drive the small instance's controls away from the active edge.
    task automatic applyStimulus(input logic c, input logic r);
        @(negedge clk);
        vsm.ce     = c;
        vsm.resync = r;
    endtask

    // Pulse reset on the small instance and leave it idle at (0,0).
    task automatic resetSmall();
        @(negedge clk);
        rst_sm     = 1'b0;
        vsm.ce     = 1'b0;
        vsm.resync = 1'b0;
        @(negedge clk);
        rst_sm = 1'b1;
    endtask

    // Reference model of the small raster: predicts the registered outputs
    // produced at each edge and queues them for the checker.
    always @(posedge clk or negedge rst_sm) begin
        if (!rst_sm) begin
            mhc    = 0;
            mvc    = 0;
            mframe = '0;
            mcur   = SM_RESET;
            expq.delete();
        end else begin
            if (vsm.ce) begin
                mcur.hsync  = (mhc < 2);
                mcur.vsync  = !(mvc < 1);
                mcur.active = (mhc >= 3) && (mhc < 8) && (mvc >= 1) && (mvc < 4);
                mcur.x      = mcur.active ? SCW'(mhc - 3) : '0;
                mcur.y      = mcur.active ? SCW'(mvc - 1) : '0;
                mcur.sof    = (mhc == 0) && (mvc == 0);
                mcur.eol    = (mhc == 9);
                if (mhc == 9 && mvc == 3) mframe = mframe + 2'd1;
            end
            mcur.frame = mframe;
            if (vsm.resync) begin
                mhc = 0;
                mvc = 0;
            end else if (vsm.ce) begin
                if (mhc == 9) begin
                    mhc = 0;
                    mvc = (mvc == 3) ? 0 : mvc + 1;
                end else begin
                    mhc = mhc + 1;
                end
            end
            expq.push_back(mcur);
        end
    end

    // Scoreboard checker: pop the prediction for the last edge and compare.
    always @(negedge clk) begin
        if (rst_sm && expq.size() > 0) begin
            obs_t e;
            e = expq.pop_front();
            checkOutput("scoreboard", 64'(sample_sm()), 64'(e));
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        int hsHigh, vsLow, eolCount, lastEol, gapBad, sofCount;
        int activeCount, activeRuns, xBad, expX, lastX, yBad, ceCount;
        logic prevActive;
        logic c;

        rst_sm     = 1'b0;
        rst_df     = 1'b0;
        vsm.ce     = 1'b0;
        vsm.resync = 1'b0;
        vdf.ce     = 1'b1;
        vdf.resync = 1'b0;

        vecs[0]  = mkv(1, 0, mko(1, 0, 0, 0, 0, 1, 0));
        vecs[1]  = mkv(0, 0, mko(1, 0, 0, 0, 0, 1, 0));
        vecs[2]  = mkv(1, 0, mko(1, 0, 0, 0, 0, 0, 0));
        vecs[3]  = mkv(1, 0, mko(0, 0, 0, 0, 0, 0, 0));
        for (int i = 4; i <= 9; i++) vecs[i] = mkv(1, 0, mko(0, 0, 0, 0, 0, 0, 0));
        vecs[10] = mkv(1, 0, mko(0, 0, 0, 0, 0, 0, 1));
        vecs[11] = mkv(0, 0, mko(0, 0, 0, 0, 0, 0, 1));
        vecs[12] = mkv(1, 0, mko(1, 1, 0, 0, 0, 0, 0));
        vecs[13] = mkv(1, 0, mko(1, 1, 0, 0, 0, 0, 0));
        vecs[14] = mkv(1, 0, mko(0, 1, 0, 0, 0, 0, 0));
        vecs[15] = mkv(1, 0, mko(0, 1, 1, 0, 0, 0, 0));
        vecs[16] = mkv(1, 0, mko(0, 1, 1, 1, 0, 0, 0));
        vecs[17] = mkv(0, 0, mko(0, 1, 1, 1, 0, 0, 0));
        vecs[18] = mkv(1, 0, mko(0, 1, 1, 2, 0, 0, 0));
        vecs[19] = mkv(1, 0, mko(0, 1, 1, 3, 0, 0, 0));
        vecs[20] = mkv(1, 0, mko(0, 1, 1, 4, 0, 0, 0));
        vecs[21] = mkv(1, 0, mko(0, 1, 0, 0, 0, 0, 0));
        vecs[22] = mkv(1, 1, mko(0, 1, 0, 0, 0, 0, 1));
        vecs[23] = mkv(1, 0, mko(1, 0, 0, 0, 0, 1, 0));

        repeat (2) @(negedge clk);
        checkOutput("sm_reset", 64'(sample_sm()), 64'(SM_RESET));
        checkOutput("df_reset",
                    64'({vdf.hsync, vdf.vsync, vdf.active, vdf.x, vdf.y,
                         vdf.sof, vdf.eol, vdf.frame}),
                    64'({1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 8'd0}));

        // Default raster, ce held high: first twenty lines.
        hsHigh = 0; vsLow = 0; eolCount = 0; lastEol = -1; gapBad = 0;
        sofCount = 0; activeCount = 0; activeRuns = 0; xBad = 0; expX = 0;
        lastX = -1; yBad = 0; prevActive = 1'b0;
        @(negedge clk);
        rst_df = 1'b1;
        for (int n = 0; n < 20 * 882; n++) begin
            @(posedge clk);
            #1;
            if (vdf.hsync) hsHigh++;
            if (!vdf.vsync) vsLow++;
            if (vdf.sof) sofCount++;
            if (vdf.eol) begin
                if (lastEol >= 0 && (n - lastEol) != 882) gapBad++;
                lastEol = n;
                eolCount++;
            end
            if (vdf.active) begin
                if (!prevActive) activeRuns++;
                if (int'(vdf.x) != expX) xBad++;
                if (vdf.y != 10'd0) yBad++;
                expX++;
                lastX = int'(vdf.x);
                activeCount++;
            end
            prevActive = vdf.active;
        end
        checkOutput("df_hsync_high", 64'(hsHigh), 64'(20 * 135));
        checkOutput("df_vsync_low", 64'(vsLow), 64'(14112));
        checkOutput("df_eol_count", 64'(eolCount), 64'(20));
        checkOutput("df_eol_period", 64'(gapBad), 64'(0));
        checkOutput("df_sof_count", 64'(sofCount), 64'(1));
        checkOutput("df_active_len", 64'(activeCount), 64'(721));
        checkOutput("df_active_runs", 64'(activeRuns), 64'(1));
        checkOutput("df_x_sequence", 64'(xBad), 64'(0));
        checkOutput("df_x_last", 64'(lastX), 64'(720));
        checkOutput("df_y_first_line", 64'(yBad), 64'(0));

        // Small raster: vector table from a fresh reset.
        @(negedge clk);
        rst_sm = 1'b1;
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].ce, vecs[i].resync);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d", i), 64'(sample_sm()), 64'(vecs[i].exp));
        end

        // Five full frames with ce high: frame counter wraps 3 -> 0 -> 1.
        resetSmall();
        applyStimulus(1, 0);
        repeat (120) @(posedge clk);
        #1;
        checkOutput("frame_3", 64'(vsm.frame), 64'(3));
        repeat (40) @(posedge clk);
        #1;
        checkOutput("frame_wrap_0", 64'(vsm.frame), 64'(0));
        repeat (40) @(posedge clk);
        #1;
        checkOutput("frame_after_5", 64'(vsm.frame), 64'(1));

        // Pseudo-random clock enable; frames depend only on enabled edges.
        resetSmall();
        ceCount = 0;
        for (int i = 0; i < 400; i++) begin
            c = 1'($urandom_range(0, 1));
            applyStimulus(c, 0);
            if (c) ceCount++;
        end
        applyStimulus(0, 0);
        checkOutput("random_ce_frame", 64'(vsm.frame), 64'((ceCount / 40) % 4));

        // Resync mid-frame with ce high.
        resetSmall();
        applyStimulus(1, 0);
        repeat (25) @(posedge clk);
        applyStimulus(1, 1);
        @(posedge clk);
        #1;
        applyStimulus(1, 0);
        @(posedge clk);
        #1;
        checkOutput("resync_sof", 64'(vsm.sof), 64'(1));
        checkOutput("resync_frame", 64'(vsm.frame), 64'(0));

        // Resync with ce low, then the following enabled edge.
        repeat (12) @(posedge clk);
        applyStimulus(0, 1);
        @(posedge clk);
        #1;
        checkOutput("resync_ce0_hold", 64'(vsm.sof), 64'(0));
        applyStimulus(1, 0);
        @(posedge clk);
        #1;
        checkOutput("resync_ce0_sof", 64'(vsm.sof), 64'(1));

        // Resync landing on the frame-wrap edge still counts the frame.
        repeat (38) @(posedge clk);
        applyStimulus(1, 1);
        @(posedge clk);
        #1;
        checkOutput("resync_wrap_frame", 64'(vsm.frame), 64'(1));
        checkOutput("resync_wrap_eol", 64'(vsm.eol), 64'(1));
        applyStimulus(1, 0);
        @(posedge clk);
        #1;
        checkOutput("resync_wrap_sof", 64'(vsm.sof), 64'(1));

        // Asynchronous reset between edges, then restart.
        repeat (7) @(posedge clk);
        #2;
        rst_sm = 1'b0;
        #1;
        checkOutput("async_reset", 64'(sample_sm()), 64'(SM_RESET));
        @(negedge clk);
        rst_sm     = 1'b1;
        vsm.ce     = 1'b1;
        vsm.resync = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post_reset_first", 64'(sample_sm()),
                    64'(mko(1, 0, 0, 0, 0, 1, 0)));

        @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
